// File: rtl/lsu_ram_ctrl.sv
// Load/store controller for a 32-bit single-port synchronous data RAM.
// Sub-word stores are read-modify-write; bad accesses never touch memory.
module lsu_ram_ctrl #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] ram_addr,
    output logic          ram_wren,
    output logic [31:0]   ram_wrdata,
    input  logic [31:0]   ram_rddata
);

    typedef enum logic [1:0] {IDLE, RD, MERGE, WR} state_t;

    state_t      state;
    logic        op_we;
    logic [2:0]  op_f3;
    logic [1:0]  op_off;
    logic [15:0] op_wdata;

    logic        legal;
    logic        misal;
    logic        bad;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic        unused_hi;

    assign unused_hi = ^req_addr[31:AW+2];
    assign req_ready = (state == IDLE) & ~rst;

    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~req_we;
            default:                legal = 1'b0;
        endcase
    end

    assign misal = ((req_funct3[1:0] == 2'b01) & req_addr[0])
                 | ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0]));
    assign bad = ~legal | misal;

    assign lane_b = ram_rddata[{op_off, 3'b000} +: 8];
    assign lane_h = op_off[1] ? ram_rddata[31:16] : ram_rddata[15:0];

    always_comb begin
        load_val = ram_rddata;
        case (op_f3)
            3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_val = {24'd0, lane_b};
            3'b101:  load_val = {16'd0, lane_h};
            default: load_val = ram_rddata;
        endcase
    end

    // only the addressed lane(s) take store data; the rest keep the read word
    always_comb begin
        merged = ram_rddata;
        if (op_f3[0])
            merged[{op_off[1], 4'b0000} +: 16] = op_wdata;
        else
            merged[{op_off, 3'b000} +: 8] = op_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_we      <= 1'b0;
            op_f3      <= 3'd0;
            op_off     <= 2'd0;
            op_wdata   <= 16'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            ram_addr   <= '0;
            ram_wren   <= 1'b0;
            ram_wrdata <= 32'd0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_we    <= req_we;
                        op_f3    <= req_funct3;
                        op_off   <= req_addr[1:0];
                        op_wdata <= req_wdata[15:0];
                        if (bad) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (req_we && req_funct3 == 3'b010) begin
                            ram_addr   <= req_addr[AW+1:2];
                            ram_wrdata <= req_wdata;
                            ram_wren   <= 1'b1;
                            state      <= WR;
                        end else begin
                            ram_addr <= req_addr[AW+1:2];
                            state    <= RD;
                        end
                    end
                end
                RD: state <= MERGE;
                MERGE: begin
                    if (op_we) begin
                        ram_wrdata <= merged;
                        ram_wren   <= 1'b1;
                        state      <= WR;
                    end else begin
                        resp_rdata <= load_val;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= IDLE;
                    end
                end
                WR: begin
                    ram_wren   <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_ram_ctrl.md
# lsu_ram_ctrl

Load/store controller between the core's MEM stage and a 32-bit-wide single-port synchronous data RAM (`ramGen`, Width=32, Depth=AW). The RAM has one-cycle read latency and no byte enables. This block therefore:
- extracts bytes and halfwords on loads, with sign or zero extension;
- implements SB/SH as a read-modify-write of the containing word;
- rejects misaligned and illegal accesses without touching memory.

## Interface
Parameters:
- AW, 10, word-address width of the attached RAM (RAM holds 2**AW 32-bit words)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept; combinational, = (state==IDLE) & ~rst
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3 of the load/store
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/half used for SB/SH
- resp_valid  out  1  one-cycle completion pulse, registered
- resp_rdata  out  32  load result (0 for stores and errors), registered, held until next response
- resp_err  out  1  misaligned/illegal access flag, valid with resp_valid, held until next response
- ram_addr  out  AW  RAM word address, registered
- ram_wren  out  1  RAM write enable, registered
- ram_wrdata  out  32  RAM write data, registered
- ram_rddata  in  32  RAM read data; reflects ram_addr as sampled on the previous edge

## Operation
- Handshake: a request is accepted on any edge where req_valid & req_ready. Request fields are latched at accept; inputs are ignored otherwise. The response path has no backpressure: the consumer must take resp_valid when it pulses.
- Word index = req_addr[AW+1:2]; req_addr[31:AW+2] is ignored. Byte offset = req_addr[1:0].
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: 000 SB, 001 SH, 010 SW.
- Any other funct3 sets resp_err=1.
- Misalignment sets resp_err=1:
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=0.
- Error requests perform no RAM access (ram_wren stays 0).
- Load extraction:
  - LB/LBU: byte selected by addr[1:0]; LH/LHU: half selected by addr[1].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU; LW passes the word through.
- Sub-word store merge: the read word has only the addressed byte lane(s) replaced by req_wdata[7:0] (SB) or req_wdata[15:0] (SH). All other lanes keep their old value.
- FSM states: IDLE, RD, MERGE, WR.
  - IDLE, accept with error: resp_valid<=1, resp_err<=1, resp_rdata<=0; stay IDLE.
  - IDLE, accept SW: ram_addr<=idx, ram_wdata<=req_wdata, ram_wren<=1; go to WR.
  - IDLE, accept load/SB/SH: ram_addr<=idx; go to RD.
  - RD: go to MERGE (ram_rddata becomes valid in MERGE).
  - MERGE, load: resp_rdata<=extracted, resp_err<=0, resp_valid<=1; go to IDLE.
  - MERGE, SB/SH: ram_wrdata<=merged, ram_wren<=1; go to WR.
  - WR: ram_wren<=0, resp_valid<=1, resp_err<=0, resp_rdata<=0; go to IDLE.
- resp_valid is cleared on every edge where it is not being set.
- ram_addr holds its value between requests.

## Timing
- Reset state: IDLE; resp_valid=0, resp_rdata=0, resp_err=0, ram_addr=0, ram_wren=0, ram_wrdata=0; req_ready=0 while rst=1.
- Accept at edge E0; resp_valid is high in the cycle after:
  - error: E0, latency 1;
  - SW: E1, latency 2;
  - load: E2, latency 3;
  - SB/SH: E3, latency 4.
- req_ready returns high in the same cycle resp_valid is high, so back-to-back requests are accepted on that cycle's edge.
- RAM write commits on the edge that ends the WR cycle. A load accepted immediately after a store's response therefore reads the new data; no forwarding is needed.
- Reset mid-operation:
  - Returns to IDLE at the reset edge; any response in flight is dropped.
  - If ram_wren was already high in that cycle, the write commits on that edge (RAM has no reset).
  - No write is issued afterwards.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → store resp 2 cycles after accept, err=0; load resp 3 cycles after accept, rdata=0xDEADBEEF.
- Word 0x80FF7F01 @0x20: LB @0x23 → 0xFFFFFF80; LBU @0x23 → 0x00000080; LH @0x22 → 0xFFFF80FF; LHU @0x20 → 0x00007F01.
- Word 0x11223344 @0x30: SB 0xAA @0x31 → word 0x1122AA44; then SH 0xBEEF @0x32 → word 0xBEEFAA44. SB/SH resp 4 cycles after accept; no other lane changes.
- LH @0x01, SW @0x06, funct3=011 → each: resp_valid 1 cycle after accept, err=1, rdata=0, ram_wren never high, memory unchanged.
- req_valid held high across SW, LW, SB stream → each accepted on the cycle its predecessor responds; resp_valid pulses exactly once per request.
- rst asserted during RD of an SB → IDLE next cycle, no resp_valid, no RAM write; all outputs at reset values.
